wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage plus architectural register file for the five-stage MIPS pipeline. Consumes the M/W pipeline register outputs (`*_W` signals), formats load data, selects the writeback value (ALU result, load data or link address) and destination, and commits it to a 32×32 register file. Serves the decode stage's two combinational read ports with internal write-through bypass, and exports the writeback bus for forwarding.

## Interface
Parameters:
- `SP_INIT`, default `32'h0000_2FFC`: reset value of `$29`.
- `GP_INIT`, default `32'h0000_1800`: reset value of `$28`.

Ports:
- `clk`  in  1  single clock for the block; all register writes occur on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RegWrite_W`  in  1  writeback enable from the M/W register.
- `MemToReg_W`  in  1  selects formatted load data.
- `IfJal_W`  in  1  `jal` link: destination `$31`, data `pcadd1_W`.
- `IfBgezal_W`  in  1  `bgezal` link: destination `$31`, data `pcadd1_W`.
- `IfJalr_W`  in  1  `jalr` link: destination `WriteReg_W`, data `pcadd1_W`.
- `IR_W`  in  32  instruction in W; opcode `IR_W[31:26]` drives load formatting.
- `ALU_out_W`  in  32  ALU result, or effective address for loads.
- `Memdata_W`  in  32  raw aligned memory word.
- `pcadd1_W`  in  32  link value.
- `WriteReg_W`  in  5  destination register for non-`jal`/`bgezal` writes.
- `rs_D`, `rt_D`  in  5 each  decode read addresses.
- `rs_data_D`, `rt_data_D`  out  32 each  decode read data.
- `wb_en`  out  1  effective write enable, for hazard and forwarding logic.
- `wb_addr`  out  5  effective destination.
- `wb_data`  out  32  effective write data.

## Operation
- **Destination:** `wb_addr = 5'd31` if `IfJal_W | IfBgezal_W`; otherwise `WriteReg_W`.
- **Enable:** `wb_en = RegWrite_W & (wb_addr != 0)`. Link flags do not enable a write on their own.
- **Data priority:**
  1. Link (`IfJal_W | IfBgezal_W | IfJalr_W`): `pcadd1_W`.
  2. Else `MemToReg_W`: formatted load.
  3. Else `ALU_out_W`.
- **Load formatting** (little-endian), with `off = ALU_out_W[1:0]`:
  - `lb` (0x20): byte `Memdata_W[8*off+7 : 8*off]`, sign-extended.
  - `lbu` (0x24): same byte, zero-extended.
  - `lh` (0x21): halfword `Memdata_W[15:0]` if `off[1]=0`, else `[31:16]`, sign-extended.
  - `lhu` (0x25): same halfword, zero-extended.
  - `lw` (0x23) and any other opcode: the full word. `off[0]` is ignored for halfwords.
- **Register file:** `$0` is hard-wired to 0. It is never written and always reads 0.
- **Reads:**
  - Combinational.
  - Read address 0 returns 0.
  - If `wb_en` and `wb_addr` equals a read address, that port returns `wb_data` (write-through bypass).
  - Otherwise the port returns the stored value.
  - Both ports bypass independently, including when `rs_D == rt_D`.
- **Reset:**
  - While `reset` is high, all registers clear to 0 except `$28 = GP_INIT` and `$29 = SP_INIT`.
  - Bypass is suppressed while `reset` is high, so read ports return the reset contents.
  - Reset takes effect immediately, without waiting for a clock edge.
- A flushed bubble (all `*_W` zero) yields `wb_en = 0` and causes no write.

## Timing
- `wb_en`, `wb_addr` and `wb_data` are purely combinational from the `*_W` inputs: zero latency.
- The register file updates on the `clk` rising edge when `wb_en` is high.
- A decode read in the same cycle sees the new value via bypass. Subsequent cycles see the stored value.
- Reset release: the first rising edge after `reset` falls may perform a write.
- Reset asserted in the same cycle as a pending write: reset wins, the write is lost, and the register holds its reset value.
- No stall input. The upstream register presents one instruction per cycle, and every cycle is committed or dropped.
- Output reset values (`*_W` inputs at 0): `wb_en = 0`, `wb_addr = 0`, `wb_data = 0`. `rs_data_D`/`rt_data_D` reflect the reset contents.

## Test plan
- **Reset:** assert `reset` mid-run, read `$29`/`$28`/`$5`, then deassert. Expect `SP_INIT`/`GP_INIT`/0 immediately. A write to `$5` presented in the reset cycle is not committed.
- **ALU write + bypass:** `RegWrite_W=1`, `WriteReg_W=8`, `ALU_out_W=32'hDEAD_BEEF`, `rs_D=rt_D=8`.
  - Both ports return `32'hDEAD_BEEF` in the same cycle.
  - After the edge, with `RegWrite_W=0`, both still return it.
- **Loads:** `Memdata_W=32'h80F1_7F82`.
  - `lb`, `off=3`: `32'hFFFF_FF80`.
  - `lbu`, `off=0`: `32'h0000_0082`.
  - `lh`, `off=2`: `32'hFFFF_80F1`.
  - `lhu`, `off=0`: `32'h0000_7F82`.
  - `lw`: `32'h80F1_7F82`.
- **Links:**
  - `IfJal_W=1`, `RegWrite_W=1`, `WriteReg_W=3`, `pcadd1_W=32'h0000_0040`: `$31=0x40` and `$3` unchanged.
  - `IfJalr_W` with `WriteReg_W=7`: `$7 = pcadd1_W`.
- **`$0` protection:** `RegWrite_W=1`, `WriteReg_W=0`, `ALU_out_W=5`.
  - `wb_en=0`.
  - `rs_D=0` reads 0 both before and after the edge.
- **Bubble:** all `*_W=0` for 3 cycles. No register changes and `wb_en` stays 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
//
// Bundles the writeback-stage signals between the M/W pipeline register, the
// decode stage and the writeback/register-file block.
//
//   *_W inputs     : control, instruction, ALU result, memory word, link value
//                    and destination from the M/W register
//   rs_D / rt_D    : decode read addresses
//   rs/rt_data_D   : decode read data (combinational, with write-through)
//   wb_en/addr/data: effective writeback bus exported for hazard/forwarding
//
// The slave modport is the register-file side. The master modport is the
// pipeline side that drives the *_W and read-address signals.
// ---------------------------------------------------------------------------
interface wb_regfile_if;
    logic        RegWrite_W;
    logic        MemToReg_W;
    logic        IfJal_W;
    logic        IfBgezal_W;
    logic        IfJalr_W;
    logic [31:0] IR_W;
    logic [31:0] ALU_out_W;
    logic [31:0] Memdata_W;
    logic [31:0] pcadd1_W;
    logic [4:0]  WriteReg_W;
    logic [4:0]  rs_D;
    logic [4:0]  rt_D;
    logic [31:0] rs_data_D;
    logic [31:0] rt_data_D;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    modport slave (
        input  RegWrite_W, MemToReg_W, IfJal_W, IfBgezal_W, IfJalr_W,
        input  IR_W, ALU_out_W, Memdata_W, pcadd1_W, WriteReg_W,
        input  rs_D, rt_D,
        output rs_data_D, rt_data_D,
        output wb_en, wb_addr, wb_data
    );

    modport master (
        output RegWrite_W, MemToReg_W, IfJal_W, IfBgezal_W, IfJalr_W,
        output IR_W, ALU_out_W, Memdata_W, pcadd1_W, WriteReg_W,
        output rs_D, rt_D,
        input  rs_data_D, rt_data_D,
        input  wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Writeback stage and 32x32 architectural register file of the five-stage
// MIPS pipeline. Formats load data, selects the writeback value and
// destination, commits it on the rising clock edge, and serves two
// combinational decode read ports with write-through bypass.
//
// Ports:
//   clk   : clock, register writes on rising edge
//   reset : asynchronous, active-high; $28 <= GP_INIT, $29 <= SP_INIT,
//           all other registers <= 0
//   wb    : wb_regfile_if.slave (M/W inputs, decode read ports, wb bus)
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_2FFC,
    parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  wb
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    // Little-endian load extraction. Halfword selection looks only at off[1].
    function automatic logic [31:0] format_load(
        input logic [5:0]  op,
        input logic [1:0]  off,
        input logic [31:0] word
    );
        logic        [7:0]  byte_sel;
        logic        [15:0] half_sel;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic        [31:0] res;
        case (off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];
        byte_s   = byte_sel;
        half_s   = half_sel;
        case (op)
            OP_LB:   res = 32'(byte_s);
            OP_LBU:  res = {24'd0, byte_sel};
            OP_LH:   res = 32'(half_s);
            OP_LHU:  res = {16'd0, half_sel};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] reset_value(input int idx);
        logic [31:0] v;
        if (idx == 28)      v = GP_INIT;
        else if (idx == 29) v = SP_INIT;
        else                v = '0;
        return v;
    endfunction

    // $0 has no storage; only $1..$31 are flops.
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    logic        link_ra;
    logic        link_any;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    // Writeback select: destination, enable and data priority
    always_comb begin
        link_ra  = wb.IfJal_W | wb.IfBgezal_W;
        link_any = link_ra | wb.IfJalr_W;
        wb_addr  = link_ra ? 5'd31 : wb.WriteReg_W;
        wb_en    = wb.RegWrite_W & (wb_addr != 5'd0);
        if (link_any)
            wb_data = wb.pcadd1_W;
        else if (wb.MemToReg_W)
            wb_data = format_load(wb.IR_W[31:26], wb.ALU_out_W[1:0], wb.Memdata_W);
        else
            wb_data = wb.ALU_out_W;
    end

    // Next register-file state
    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_en && (wb_addr == 5'(i)))
                regs_d[i] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++)
                regs_q[i] <= reset_value(i);
        end else begin
            for (int i = 1; i < 32; i++)
                regs_q[i] <= regs_d[i];
        end
    end

    // Decode read ports. Bypass is held off during reset so readers see the
    // reset contents rather than a write that will never commit.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (wb.rs_D != 5'd0) begin
            if (wb_en && !reset && (wb_addr == wb.rs_D))
                rs_data = wb_data;
            else
                rs_data = regs_q[wb.rs_D];
        end
        if (wb.rt_D != 5'd0) begin
            if (wb_en && !reset && (wb_addr == wb.rt_D))
                rt_data = wb_data;
            else
                rt_data = regs_q[wb.rt_D];
        end
    end

    assign wb.wb_en     = wb_en;
    assign wb.wb_addr   = wb_addr;
    assign wb.wb_data   = wb_data;
    assign wb.rs_data_D = rs_data;
    assign wb.rt_data_D = rt_data;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    localparam logic [31:0] SP = 32'h0000_2FFC;
    localparam logic [31:0] GP = 32'h0000_1800;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    wb_regfile_if bus ();

    wb_regfile #(.SP_INIT(SP), .GP_INIT(GP)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_w();
        bus.RegWrite_W = 1'b0;
        bus.MemToReg_W = 1'b0;
        bus.IfJal_W    = 1'b0;
        bus.IfBgezal_W = 1'b0;
        bus.IfJalr_W   = 1'b0;
        bus.IR_W       = '0;
        bus.ALU_out_W  = '0;
        bus.Memdata_W  = '0;
        bus.pcadd1_W   = '0;
        bus.WriteReg_W = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_write(input logic [4:0] r, input logic [31:0] v);
        clear_w();
        bus.RegWrite_W = 1'b1;
        bus.WriteReg_W = r;
        bus.ALU_out_W  = v;
        tick();
        clear_w();
    endtask

    task automatic test_reset();
        // reset held from time 0
        #1;
        total++;
        if (bus.wb_en !== 1'b0 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_wb_bus: got en=%b addr=%0d data=%h want 0/0/0",
                     bus.wb_en, bus.wb_addr, bus.wb_data);
        end
        bus.rs_D = 5'd29; bus.rt_D = 5'd28; #1;
        total++;
        if (bus.rs_data_D !== SP || bus.rt_data_D !== GP) begin
            bad++;
            $display("FAIL reset_sp_gp: got %h %h want %h %h", bus.rs_data_D, bus.rt_data_D, SP, GP);
        end
        tick();
        reset = 1'b0;
        // dirty $5 and $29 so the mid-run reset has something to restore
        alu_write(5'd5, 32'h0000_0055);
        alu_write(5'd29, 32'h0000_1234);
        bus.rs_D = 5'd5; bus.rt_D = 5'd29; #1;
        total++;
        if (bus.rs_data_D !== 32'h55 || bus.rt_data_D !== 32'h1234) begin
            bad++;
            $display("FAIL pre_reset_regs: got %h %h want 00000055 00001234", bus.rs_data_D, bus.rt_data_D);
        end
        // pending write to $5, then reset asserted mid-cycle
        bus.RegWrite_W = 1'b1; bus.WriteReg_W = 5'd5; bus.ALU_out_W = 32'h0000_AAAA;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (bus.rs_data_D !== 32'd0 || bus.rt_data_D !== SP) begin
            bad++;
            $display("FAIL midrun_reset_5_29: got %h %h want 00000000 %h", bus.rs_data_D, bus.rt_data_D, SP);
        end
        bus.rt_D = 5'd28; #1;
        total++;
        if (bus.rt_data_D !== GP) begin
            bad++;
            $display("FAIL midrun_reset_28: got %h want %h", bus.rt_data_D, GP);
        end
        tick();
        reset = 1'b0;
        clear_w();
        bus.rs_D = 5'd5; #1;
        total++;
        if (bus.rs_data_D !== 32'd0) begin
            bad++;
            $display("FAIL reset_write_lost: got %h want 00000000", bus.rs_data_D);
        end
        // first edge after release commits
        alu_write(5'd6, 32'h0000_0066);
        bus.rs_D = 5'd6; #1;
        total++;
        if (bus.rs_data_D !== 32'h66) begin
            bad++;
            $display("FAIL first_write_after_reset: got %h want 00000066", bus.rs_data_D);
        end
    endtask

    task automatic test_alu_bypass();
        clear_w();
        bus.RegWrite_W = 1'b1; bus.WriteReg_W = 5'd8; bus.ALU_out_W = 32'hDEAD_BEEF;
        bus.rs_D = 5'd8; bus.rt_D = 5'd8; #1;
        total++;
        if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd8 || bus.wb_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL alu_wb_bus: got en=%b addr=%0d data=%h want 1/8/deadbeef",
                     bus.wb_en, bus.wb_addr, bus.wb_data);
        end
        total++;
        if (bus.rs_data_D !== 32'hDEAD_BEEF || bus.rt_data_D !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL alu_bypass: got %h %h want deadbeef deadbeef", bus.rs_data_D, bus.rt_data_D);
        end
        tick();
        clear_w(); #1;
        total++;
        if (bus.rs_data_D !== 32'hDEAD_BEEF || bus.rt_data_D !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL alu_stored: got %h %h want deadbeef deadbeef", bus.rs_data_D, bus.rt_data_D);
        end
    endtask

    task automatic test_loads();
        logic [5:0]  ops  [9] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h20, 6'h24, 6'h21, 6'h00};
        logic [1:0]  offs [9] = '{2'd3,  2'd0,  2'd2,  2'd0,  2'd0,  2'd2,  2'd1,  2'd3,  2'd1};
        logic [31:0] exps [9] = '{32'hFFFF_FF80, 32'h0000_0082, 32'hFFFF_80F1, 32'h0000_7F82,
                                  32'h80F1_7F82, 32'hFFFF_FFF1, 32'h0000_007F, 32'hFFFF_80F1,
                                  32'h80F1_7F82};
        for (int i = 0; i < 9; i++) begin
            clear_w();
            bus.RegWrite_W = 1'b1;
            bus.MemToReg_W = 1'b1;
            bus.WriteReg_W = 5'd9;
            bus.Memdata_W  = 32'h80F1_7F82;
            bus.IR_W       = {ops[i], 26'd0};
            bus.ALU_out_W  = {30'h0000_1000, offs[i]};
            bus.rs_D       = 5'd0;
            bus.rt_D       = 5'd9;
            #1;
            total++;
            if (bus.wb_data !== exps[i]) begin
                bad++;
                $display("FAIL load_%0d op=%h off=%0d: got %h want %h", i, ops[i], offs[i], bus.wb_data, exps[i]);
            end
            tick();
            clear_w(); #1;
            total++;
            if (bus.rt_data_D !== exps[i]) begin
                bad++;
                $display("FAIL load_stored_%0d: got %h want %h", i, bus.rt_data_D, exps[i]);
            end
        end
    endtask

    task automatic test_links();
        alu_write(5'd3, 32'h0000_0033);
        bus.RegWrite_W = 1'b1; bus.IfJal_W = 1'b1; bus.WriteReg_W = 5'd3;
        bus.pcadd1_W = 32'h0000_0040; bus.ALU_out_W = 32'h0000_0999;
        #1;
        total++;
        if (bus.wb_en !== 1'b1 || bus.wb_addr !== 5'd31 || bus.wb_data !== 32'h40) begin
            bad++;
            $display("FAIL jal_wb_bus: got en=%b addr=%0d data=%h want 1/31/00000040",
                     bus.wb_en, bus.wb_addr, bus.wb_data);
        end
        tick();
        clear_w();
        bus.rs_D = 5'd31; bus.rt_D = 5'd3; #1;
        total++;
        if (bus.rs_data_D !== 32'h40 || bus.rt_data_D !== 32'h33) begin
            bad++;
            $display("FAIL jal_commit: got $31=%h $3=%h want 00000040 00000033", bus.rs_data_D, bus.rt_data_D);
        end
        // jalr wins over MemToReg and uses WriteReg_W
        bus.RegWrite_W = 1'b1; bus.IfJalr_W = 1'b1; bus.MemToReg_W = 1'b1;
        bus.WriteReg_W = 5'd7; bus.pcadd1_W = 32'h0000_0080; bus.Memdata_W = 32'h1111_2222;
        tick();
        clear_w();
        bus.rs_D = 5'd7; #1;
        total++;
        if (bus.rs_data_D !== 32'h80) begin
            bad++;
            $display("FAIL jalr_commit: got %h want 00000080", bus.rs_data_D);
        end
        bus.RegWrite_W = 1'b1; bus.IfBgezal_W = 1'b1; bus.WriteReg_W = 5'd2;
        bus.pcadd1_W = 32'h0000_00C4;
        tick();
        clear_w();
        bus.rs_D = 5'd31; bus.rt_D = 5'd2; #1;
        total++;
        if (bus.rs_data_D !== 32'hC4 || bus.rt_data_D !== 32'd0) begin
            bad++;
            $display("FAIL bgezal_commit: got $31=%h $2=%h want 000000c4 00000000", bus.rs_data_D, bus.rt_data_D);
        end
        // link flag without RegWrite_W does not write
        bus.IfJal_W = 1'b1; bus.pcadd1_W = 32'h0000_0100; #1;
        total++;
        if (bus.wb_en !== 1'b0) begin
            bad++;
            $display("FAIL jal_no_regwrite_en: got %b want 0", bus.wb_en);
        end
        tick();
        clear_w(); #1;
        total++;
        if (bus.rs_data_D !== 32'hC4) begin
            bad++;
            $display("FAIL jal_no_regwrite_keep: got %h want 000000c4", bus.rs_data_D);
        end
    endtask

    task automatic test_zero_reg();
        clear_w();
        bus.RegWrite_W = 1'b1; bus.WriteReg_W = 5'd0; bus.ALU_out_W = 32'd5;
        bus.rs_D = 5'd0; bus.rt_D = 5'd0; #1;
        total++;
        if (bus.wb_en !== 1'b0 || bus.rs_data_D !== 32'd0) begin
            bad++;
            $display("FAIL zero_reg_before: got en=%b rs=%h want 0 00000000", bus.wb_en, bus.rs_data_D);
        end
        tick();
        clear_w(); #1;
        total++;
        if (bus.rs_data_D !== 32'd0) begin
            bad++;
            $display("FAIL zero_reg_after: got %h want 00000000", bus.rs_data_D);
        end
    endtask

    task automatic test_bubble();
        clear_w();
        bus.rs_D = 5'd8; bus.rt_D = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (bus.wb_en !== 1'b0 || bus.rs_data_D !== 32'hDEAD_BEEF || bus.rt_data_D !== 32'h80) begin
                bad++;
                $display("FAIL bubble_%0d: got en=%b $8=%h $7=%h want 0 deadbeef 00000080",
                         c, bus.wb_en, bus.rs_data_D, bus.rt_data_D);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        clear_w();
        bus.rs_D = 5'd10; bus.rt_D = 5'd11;
        bus.RegWrite_W = 1'b1; bus.WriteReg_W = 5'd10; bus.ALU_out_W = 32'hA0A0_A0A0; #1;
        total++;
        if (bus.rs_data_D !== 32'hA0A0_A0A0 || bus.rt_data_D !== 32'd0) begin
            bad++;
            $display("FAIL b2b_cycle1: got %h %h want a0a0a0a0 00000000", bus.rs_data_D, bus.rt_data_D);
        end
        tick();
        bus.WriteReg_W = 5'd11; bus.ALU_out_W = 32'hB1B1_B1B1; #1;
        total++;
        if (bus.rs_data_D !== 32'hA0A0_A0A0 || bus.rt_data_D !== 32'hB1B1_B1B1) begin
            bad++;
            $display("FAIL b2b_cycle2: got %h %h want a0a0a0a0 b1b1b1b1", bus.rs_data_D, bus.rt_data_D);
        end
        tick();
        clear_w(); #1;
        total++;
        if (bus.rs_data_D !== 32'hA0A0_A0A0 || bus.rt_data_D !== 32'hB1B1_B1B1) begin
            bad++;
            $display("FAIL b2b_stored: got %h %h want a0a0a0a0 b1b1b1b1", bus.rs_data_D, bus.rt_data_D);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear_w();
        bus.rs_D = 5'd0;
        bus.rt_D = 5'd0;
        test_reset();
        test_alu_bypass();
        test_loads();
        test_links();
        test_zero_reg();
        test_bubble();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
